// File: rtl/btn_evt_pkg.sv
// Shared event codes and FSM state type for the push-button event decoder.
package btn_evt_pkg;

  localparam logic [1:0] EVT_CLICK  = 2'b00;
  localparam logic [1:0] EVT_DOUBLE = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_REPEAT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS1   = 3'd1,
    ST_RELEASE1 = 3'd2,
    ST_PRESS2   = 3'd3,
    ST_HELD     = 3'd4
  } state_t;

endpackage

// File: rtl/evt_hold_reg.sv
// Single-entry valid/ready event holding register with sticky overflow flag.
module evt_hold_reg (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_we,
  input  logic [1:0] in_code,
  output logic       out_valid,
  output logic [1:0] out_code,
  input  logic       out_ready,
  output logic       ovf
);

  logic       valid_q;
  logic [1:0] code_q;
  logic       ovf_q;

  // A write while full is accepted only if the consumer drains in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (in_we) begin
      if (!valid_q || out_ready) begin
        valid_q <= 1'b1;
        code_q  <= in_code;
      end else begin
        ovf_q <= 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_code  = code_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into CLICK/DOUBLE/LONG events.
// Define BTN_REPEAT_EN to also emit periodic REPEAT events while held after LONG.
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned LONG_TICKS   = 10000000,
  parameter int unsigned GAP_TICKS    = 3000000,
  parameter int unsigned REPEAT_TICKS = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       db_level,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_ovf
);

  localparam longint unsigned TICK_LIMIT = 64'd1 << CNT_W;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
`endif

  if (LONG_TICKS == 0 || GAP_TICKS == 0 || REPEAT_TICKS == 0 ||
      64'(LONG_TICKS) >= TICK_LIMIT || 64'(GAP_TICKS) >= TICK_LIMIT ||
      64'(REPEAT_TICKS) >= TICK_LIMIT) begin : g_bad_cfg
    $error("button_event_decoder: tick parameters must be in 1 .. 2**CNT_W-1");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             lvl_q;
  logic             rise, fall;
  logic             emit;
  logic [1:0]       emit_code;
  logic             rep_clr;

  assign rise = db_level & ~lvl_q;
  assign fall = ~db_level & lvl_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lvl_q   <= db_level;
    end
  end

  // Edges are tested before timer compares so a release on the deadline wins.
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_code = EVT_CLICK;
    rep_clr   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (fall) begin
          state_d = ST_RELEASE1;
        end else if (timer_q == LONG_LAST) begin
          state_d   = ST_HELD;
          emit      = 1'b1;
          emit_code = EVT_LONG;
        end
      end
      ST_RELEASE1: begin
        if (rise) begin
          state_d = ST_PRESS2;
        end else if (timer_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          emit      = 1'b1;
          emit_code = EVT_CLICK;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          state_d   = ST_IDLE;
          emit      = 1'b1;
          emit_code = EVT_DOUBLE;
        end
      end
      ST_HELD: begin
        if (fall) begin
          state_d = ST_IDLE;
        end
`ifdef BTN_REPEAT_EN
        else if (timer_q == REP_LAST) begin
          emit      = 1'b1;
          emit_code = EVT_REPEAT;
          rep_clr   = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q || rep_clr) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + CNT_W'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  evt_hold_reg u_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_we     (emit),
    .in_code   (emit_code),
    .out_valid (evt_valid),
    .out_code  (evt_code),
    .out_ready (evt_ready),
    .ovf       (evt_ovf)
  );

endmodule
